// File: rtl/sym_cn_lut_loader_if.sv
// sym_cn_lut_loader_if: load control, entry stream and CN LUT write-port bundle.
// Rev 1.0 - initial release.
`default_nettype none

interface sym_cn_lut_loader_if #(
  parameter int ENTRY_W = 3,
  parameter int PAGE_AW = 5
);
  logic               load_start;
  logic               load_offset;
  logic               load_busy;
  logic               load_done;
  logic               load_err;
  logic [ENTRY_W-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [ENTRY_W-1:0] lut_in_bank0;
  logic [ENTRY_W-1:0] lut_in_bank1;
  logic [PAGE_AW-1:0] page_write_addr;
  logic               write_addr_offset;
  logic               we;

  // master is the loader itself; slave is the surrounding source/LUT side
  modport master (
    input  load_start, load_offset, in_data, in_valid, in_last,
    output load_busy, load_done, load_err, in_ready,
           lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we
  );

  modport slave (
    output load_start, load_offset, in_data, in_valid, in_last,
    input  load_busy, load_done, load_err, in_ready,
           lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we
  );
endinterface

`default_nettype wire

// File: rtl/sym_cn_lut_loader.sv
// sym_cn_lut_loader: pairs a serial entry stream into bank0/bank1 words and writes PAGE_NUM pages.
// Rev 1.0 - initial release.
`default_nettype none

module sym_cn_lut_loader #(
  parameter int ENTRY_W  = 3,
  parameter int PAGE_AW  = 5,
  parameter int PAGE_NUM = 32
) (
  input  logic                 write_clk,
  input  logic                 rst,
  sym_cn_lut_loader_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL0 = 3'd1;
  localparam logic [2:0] S_FILL1 = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [PAGE_AW-1:0] LAST_PAGE = PAGE_AW'(PAGE_NUM - 1);

  logic [2:0]         state_q, state_d;
  logic [PAGE_AW-1:0] page_cnt_q, page_cnt_d;
  logic [ENTRY_W-1:0] hold_q;
  logic [ENTRY_W-1:0] bank0_q, bank1_q;
  logic [PAGE_AW-1:0] addr_q;
  logic               offset_q;
  logic               err_q;

  logic fill_w;
  logic beat_acc_w;
  logic final_beat_w;
  logic start_acc_w;

  assign fill_w       = (state_q == S_FILL0) || (state_q == S_FILL1);
  assign beat_acc_w   = fill_w && bus.in_valid;
  assign final_beat_w = (state_q == S_FILL1) && (page_cnt_q == LAST_PAGE);
  assign start_acc_w  = (state_q == S_IDLE) && bus.load_start;

  always_comb begin
    state_d    = state_q;
    page_cnt_d = page_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d    = S_FILL0;
          page_cnt_d = '0;
        end
      end
      S_FILL0: if (bus.in_valid) state_d = S_FILL1;
      S_FILL1: if (bus.in_valid) state_d = S_WRITE;
      S_WRITE: begin
        if (page_cnt_q == LAST_PAGE) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_FILL0;
          page_cnt_d = page_cnt_q + PAGE_AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      page_cnt_q <= '0;
      hold_q     <= '0;
      bank0_q    <= '0;
      bank1_q    <= '0;
      addr_q     <= '0;
      offset_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_cnt_q <= page_cnt_d;
      if (start_acc_w) begin
        offset_q <= bus.load_offset;
        err_q    <= 1'b0;
      end
      if (beat_acc_w && (state_q == S_FILL0)) begin
        hold_q <= bus.in_data;
      end
      // The write word is only published once both halves are in, so the LUT side sees a stable pair
      if (beat_acc_w && (state_q == S_FILL1)) begin
        bank0_q <= hold_q;
        bank1_q <= bus.in_data;
        addr_q  <= page_cnt_q;
      end
      if (beat_acc_w && (bus.in_last != final_beat_w)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready          = fill_w;
  assign bus.we                = (state_q == S_WRITE);
  assign bus.load_busy         = (state_q != S_IDLE);
  assign bus.load_done         = (state_q == S_DONE);
  assign bus.load_err          = err_q;
  assign bus.lut_in_bank0      = bank0_q;
  assign bus.lut_in_bank1      = bank1_q;
  assign bus.page_write_addr   = addr_q;
  assign bus.write_addr_offset = offset_q;

endmodule

`default_nettype wire

// File: tb/tb_sym_cn_lut_loader.sv
// tb_sym_cn_lut_loader: scoreboard bench for two loader instances (PAGE_NUM 32 and 4).
// Rev 1.0 - initial release.
`default_nettype none

module tb_sym_cn_lut_loader;
  localparam int EW = 3;
  localparam int AW = 5;

  typedef struct packed {
    logic          off;
    logic [AW-1:0] addr;
    logic [EW-1:0] b0;
    logic [EW-1:0] b1;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sym_cn_lut_loader_if #(.ENTRY_W(EW), .PAGE_AW(AW)) busA ();
  sym_cn_lut_loader_if #(.ENTRY_W(EW), .PAGE_AW(AW)) busB ();

  sym_cn_lut_loader #(.ENTRY_W(EW), .PAGE_AW(AW), .PAGE_NUM(32)) dut_a (
    .write_clk (clk),
    .rst       (rst),
    .bus       (busA.master)
  );

  sym_cn_lut_loader #(.ENTRY_W(EW), .PAGE_AW(AW), .PAGE_NUM(4)) dut_b (
    .write_clk (clk),
    .rst       (rst),
    .bus       (busB.master)
  );

  logic          sel = 1'b0;
  logic          d_start = 1'b0;
  logic          d_off = 1'b0;
  logic          d_valid = 1'b0;
  logic          d_last = 1'b0;
  logic [EW-1:0] d_data = '0;

  assign busA.load_start  = d_start & ~sel;
  assign busA.load_offset = d_off;
  assign busA.in_valid    = d_valid & ~sel;
  assign busA.in_last     = d_last;
  assign busA.in_data     = d_data;
  assign busB.load_start  = d_start & sel;
  assign busB.load_offset = d_off;
  assign busB.in_valid    = d_valid & sel;
  assign busB.in_last     = d_last;
  assign busB.in_data     = d_data;

  int  cyc = 0;
  int  nchk = 0;
  int  nerr = 0;
  int  weA = 0, weB = 0, doneA = 0, doneB = 0;
  int  done_cyc = 0;
  int  start_cyc = 0;
  logic cur_off = 1'b0;
  wr_t expA[$];
  wr_t expB[$];

  // cyc after edge n reads n both at posedge+1 and at the following negedge
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t  o;
    wr_t  e;
    logic w;
    for (int k = 0; k < 2; k++) begin
      w = k ? busB.we : busA.we;
      o = k ? {busB.write_addr_offset, busB.page_write_addr, busB.lut_in_bank0, busB.lut_in_bank1}
            : {busA.write_addr_offset, busA.page_write_addr, busA.lut_in_bank0, busA.lut_in_bank1};
      if (w) begin
        nchk++;
        if ((k ? expB.size() : expA.size()) == 0) begin
          nerr++;
          $display("FAIL unexpected_we dut%0d: got off=%0d addr=%0d b0=%0d b1=%0d, required no write",
                   k, o.off, o.addr, o.b0, o.b1);
        end else begin
          e = k ? expB.pop_front() : expA.pop_front();
          if (o !== e) begin
            nerr++;
            $display("FAIL write_word dut%0d: got off=%0d addr=%0d b0=%0d b1=%0d, required off=%0d addr=%0d b0=%0d b1=%0d",
                     k, o.off, o.addr, o.b0, o.b1, e.off, e.addr, e.b0, e.b1);
          end
        end
        if (k == 1) weB++; else weA++;
      end
    end
    if (busA.load_done) begin doneA++; done_cyc = cyc; end
    if (busB.load_done) begin doneB++; done_cyc = cyc; end
  end

  function automatic logic cur_rdy();  return sel ? busB.in_ready  : busA.in_ready;  endfunction
  function automatic logic cur_busy(); return sel ? busB.load_busy : busA.load_busy; endfunction
  function automatic logic cur_err();  return sel ? busB.load_err  : busA.load_err;  endfunction
  function automatic int   cur_we();   return sel ? weB : weA;     endfunction
  function automatic int   cur_done(); return sel ? doneB : doneA; endfunction

  task automatic start_load(input logic off);
    d_start = 1'b1;
    d_off   = off;
    @(posedge clk); #1;
    start_cyc = cyc;
    cur_off   = off;
    d_start   = 1'b0;
  endtask

  task automatic send_beat(input int b, input int nbeats, input int last_mode, input bit gaps);
    int   w;
    logic acc;
    wr_t  e;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      d_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    d_valid = 1'b1;
    d_data  = EW'(b % 8);
    case (last_mode)
      1:       d_last = (b == 5) || (b == nbeats - 1);
      2:       d_last = 1'b0;
      default: d_last = (b == nbeats - 1);
    endcase
    w = 0;
    forever begin
      acc = cur_rdy();
      @(posedge clk); #1;
      if (acc) break;
      w++;
      if (w > 20) begin
        nchk++;
        nerr++;
        $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles, required acceptance", b, w);
        break;
      end
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    if ((b % 2) == 1) begin
      e = '{off: cur_off, addr: AW'(b / 2), b0: EW'((b - 1) % 8), b1: EW'(b % 8)};
      if (sel) expB.push_back(e); else expA.push_back(e);
    end
  endtask

  task automatic run_load(input logic off, input bit gaps, input int last_mode, input bit poke,
                          input logic exp_err);
    int npages, nb, we0, d0, w;
    npages = sel ? 4 : 32;
    nb     = 2 * npages;
    we0    = cur_we();
    d0     = cur_done();
    start_load(off);
    nchk++;
    if ({cur_busy(), cur_err()} !== 2'b10) begin
      nerr++;
      $display("FAIL start_state: got busy=%0d err=%0d, required busy=1 err=0", cur_busy(), cur_err());
    end
    for (int b = 0; b < nb; b++) begin
      if (poke && b == 20) begin d_start = 1'b1; d_off = ~off; end
      send_beat(b, nb, last_mode, gaps);
      if (poke && b == 20) d_start = 1'b0;
      if (last_mode == 1 && b == 5) begin
        nchk++;
        if (cur_err() !== 1'b1) begin
          nerr++;
          $display("FAIL err_early: got load_err=%0d after beat 5, required 1", cur_err());
        end
      end
    end
    if (poke) begin
      @(posedge clk); #1;
      d_start = 1'b1;
      d_off   = ~off;
      @(posedge clk); #1;
      d_start = 1'b0;
      nchk++;
      if (cur_busy() !== 1'b0) begin
        nerr++;
        $display("FAIL start_on_done: got load_busy=%0d after DONE, required 0", cur_busy());
      end
    end
    w = 0;
    while (cur_done() == d0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (cur_done() - d0 !== 1) begin
      nerr++;
      $display("FAIL done_count: got %0d done pulses, required 1", cur_done() - d0);
    end
    nchk++;
    if (cur_we() - we0 !== npages) begin
      nerr++;
      $display("FAIL we_count: got %0d we pulses, required %0d", cur_we() - we0, npages);
    end
    nchk++;
    if ((sel ? expB.size() : expA.size()) != 0) begin
      nerr++;
      $display("FAIL missing_writes: got %0d expected writes not seen, required 0",
               sel ? expB.size() : expA.size());
    end
    if (!gaps) begin
      nchk++;
      if (done_cyc - start_cyc !== 3 * npages) begin
        nerr++;
        $display("FAIL done_latency: got %0d cycles after start, required %0d",
                 done_cyc - start_cyc, 3 * npages);
      end
    end
    nchk++;
    if (cur_err() !== exp_err) begin
      nerr++;
      $display("FAIL load_err_final: got %0d, required %0d", cur_err(), exp_err);
    end
  endtask

  task automatic test_reset();
    logic [16:0] oa, ob;
    oa = {busA.in_ready, busA.we, busA.load_busy, busA.load_done, busA.load_err,
          busA.lut_in_bank0, busA.lut_in_bank1, busA.page_write_addr, busA.write_addr_offset};
    ob = {busB.in_ready, busB.we, busB.load_busy, busB.load_done, busB.load_err,
          busB.lut_in_bank0, busB.lut_in_bank1, busB.page_write_addr, busB.write_addr_offset};
    nchk++;
    if (oa !== 17'd0) begin nerr++; $display("FAIL reset_outputs_a: got %h, required 0", oa); end
    nchk++;
    if (ob !== 17'd0) begin nerr++; $display("FAIL reset_outputs_b: got %h, required 0", ob); end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_load(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    sel = 1'b0;
    run_load(1'b1, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    sel = 1'b0;
    run_load(1'b0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    logic [16:0] oa;
    int we0, d0;
    sel = 1'b0;
    start_load(1'b1);
    for (int b = 0; b <= 34; b++) send_beat(b, 64, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    oa = {busA.in_ready, busA.we, busA.load_busy, busA.load_done, busA.load_err,
          busA.lut_in_bank0, busA.lut_in_bank1, busA.page_write_addr, busA.write_addr_offset};
    nchk++;
    if (oa !== 17'd0) begin nerr++; $display("FAIL abort_outputs: got %h, required 0", oa); end
    rst = 1'b0;
    we0 = weA;
    d0  = doneA;
    repeat (10) @(posedge clk);
    #1;
    nchk++;
    if ((weA != we0) || (doneA != d0)) begin
      nerr++;
      $display("FAIL abort_quiet: got %0d we and %0d done after abort, required 0 and 0",
               weA - we0, doneA - d0);
    end
    run_load(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_err_early();
    sel = 1'b0;
    run_load(1'b1, 1'b0, 1, 1'b0, 1'b1);
    run_load(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_err_never();
    sel = 1'b0;
    run_load(1'b0, 1'b0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_pagenum4();
    sel = 1'b1;
    run_load(1'b1, 1'b0, 0, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_gaps();
    test_ignore_start();
    test_reset_abort();
    test_err_early();
    test_err_never();
    test_pagenum4();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
